// File: rtl/mux2_arb_pkg.sv
// Shared constants for the round-robin 2:1 mux arbiter: source IDs, output-register
// state encoding and the default data width.
package mux2_arb_pkg;

    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

    localparam logic [0:0] EMPTY = 1'b0;
    localparam logic [0:0] FULL  = 1'b1;

    localparam int DATA_W = 4;

    typedef logic src_t;

    function automatic src_t otherSrc(input src_t s);
        return (s == SRC_A) ? SRC_B : SRC_A;
    endfunction

endpackage

// File: rtl/mux2_rr_arbiter_if.sv
// Bus bundle for mux2_rr_arbiter: two requester handshakes plus the downstream output.
// Counter signals exist only when MUX2_RR_ARBITER_STATS_EN is defined.
interface mux2_rr_arbiter_if
    import mux2_arb_pkg::*;
#(
    parameter int W = DATA_W
) ();

    logic         a_valid;
    logic [W-1:0] a_data;
    logic         a_ready;
    logic         b_valid;
    logic [W-1:0] b_data;
    logic         b_ready;
    logic         sel;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] X;
    logic         out_src;
`ifdef MUX2_RR_ARBITER_STATS_EN
    logic [7:0]   cnt_a;
    logic [7:0]   cnt_b;
`endif

    modport slave (
        input  a_valid, a_data, b_valid, b_data, out_ready,
        output a_ready, b_ready, sel, out_valid, X, out_src
`ifdef MUX2_RR_ARBITER_STATS_EN
        , output cnt_a, cnt_b
`endif
    );

    modport master (
        output a_valid, a_data, b_valid, b_data, out_ready,
        input  a_ready, b_ready, sel, out_valid, X, out_src
`ifdef MUX2_RR_ARBITER_STATS_EN
        , input cnt_a, cnt_b
`endif
    );

endinterface

// File: rtl/mux2_rr_arbiter_mux2w.sv
// Parameterized W-bit combinational 2:1 mux used as the arbiter's shared datapath.
module mux2w #(
    parameter int W = 4
) (
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    input  logic         S,
    output logic [W-1:0] X
);

    assign X = S ? B : A;

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Round-robin arbiter sharing one 2:1 mux between requesters A and B, feeding a
// one-entry output register. Define MUX2_RR_ARBITER_STATS_EN for per-source counters.
module mux2_rr_arbiter
    import mux2_arb_pkg::*;
#(
    parameter int W = DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    mux2_rr_arbiter_if.slave  bus
);

    logic [0:0]   r_state;
    logic [W-1:0] r_x;
    logic         r_outSrc;
    logic         r_lastGrant;
    logic         r_sel;

    logic         w_grantA;
    logic         w_grantB;
    logic         w_sel;
    logic         w_canAccept;
    logic         w_aReady;
    logic         w_bReady;
    logic         w_accept;
    logic [W-1:0] w_muxOut;

    // On a tie the requester that did not win the last accepted word goes first.
    always_comb begin
        w_grantA = 1'b0;
        w_grantB = 1'b0;
        if (bus.a_valid && bus.b_valid) begin
            if (r_lastGrant == SRC_B) begin
                w_grantA = 1'b1;
            end else begin
                w_grantB = 1'b1;
            end
        end else if (bus.a_valid) begin
            w_grantA = 1'b1;
        end else if (bus.b_valid) begin
            w_grantB = 1'b1;
        end
    end

    assign w_sel       = w_grantB ? SRC_B : (w_grantA ? SRC_A : r_sel);
    assign w_canAccept = (r_state == EMPTY) || bus.out_ready;
    assign w_aReady    = rst_n && w_grantA && w_canAccept;
    assign w_bReady    = rst_n && w_grantB && w_canAccept;
    assign w_accept    = w_aReady || w_bReady;

    mux2w #(.W(W)) u_mux (
        .A (bus.a_data),
        .B (bus.b_data),
        .S (w_sel),
        .X (w_muxOut)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= EMPTY;
            r_x         <= '0;
            r_outSrc    <= SRC_A;
            r_lastGrant <= SRC_B;
            r_sel       <= SRC_A;
        end else begin
            r_sel <= w_sel;
            if (w_accept) begin
                r_x         <= w_muxOut;
                r_outSrc    <= w_sel;
                r_lastGrant <= w_sel;
                r_state     <= FULL;
            end else if ((r_state == FULL) && bus.out_ready) begin
                r_state <= EMPTY;
            end
        end
    end

`ifdef MUX2_RR_ARBITER_STATS_EN
    logic [7:0] r_cntA;
    logic [7:0] r_cntB;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cntA <= '0;
            r_cntB <= '0;
        end else begin
            if (w_aReady) r_cntA <= r_cntA + 8'd1;
            if (w_bReady) r_cntB <= r_cntB + 8'd1;
        end
    end

    assign bus.cnt_a = r_cntA;
    assign bus.cnt_b = r_cntB;
`endif

    assign bus.a_ready   = w_aReady;
    assign bus.b_ready   = w_bReady;
    assign bus.sel       = w_sel;
    assign bus.out_valid = (r_state == FULL);
    assign bus.X         = r_x;
    assign bus.out_src   = r_outSrc;

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Scoreboard testbench for mux2_rr_arbiter: directed scenarios plus random traffic
// against a transaction-level round-robin model.
module tb_mux2_rr_arbiter;

    localparam int W = 4;

    typedef struct {
        logic [W-1:0] data;
        logic         src;
        int           cyc;
    } exp_t;

    logic clk;
    logic rst_n;

    mux2_rr_arbiter_if #(.W(W)) bus ();

    mux2_rr_arbiter #(.W(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    bit   monEn  = 0;
    logic mLast;
    logic mSel;
    bit   selKnown;
    bit   mAccA;
    bit   mAccB;
    int   mCntA;
    int   mCntB;

    task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic modelReset();
        expQ.delete();
        mLast    = 1'b1;
        mSel     = 1'b0;
        selKnown = 0;
        mAccA    = 0;
        mAccB    = 0;
        mCntA    = 0;
        mCntB    = 0;
    endtask

    // Expected arbitration for the current cycle; a handshake becomes a scoreboard entry.
    task automatic checkOutput();
        bit   gA, gB, full, canAcc, anyValid;
        logic expSel;
        full     = (expQ.size() != 0);
        canAcc   = !full || bus.out_ready;
        anyValid = bus.a_valid || bus.b_valid;
        gA = bus.a_valid && (!bus.b_valid || mLast == 1'b1);
        gB = bus.b_valid && (!bus.a_valid || mLast == 1'b0);
        expSel = gA ? 1'b0 : (gB ? 1'b1 : mSel);
        mAccA = gA && canAcc;
        mAccB = gB && canAcc;
        compare("a_ready", 32'(bus.a_ready), 32'(mAccA));
        compare("b_ready", 32'(bus.b_ready), 32'(mAccB));
        if (anyValid || selKnown) compare("sel", 32'(bus.sel), 32'(expSel));
        mSel = expSel;
        if (anyValid) selKnown = 1;
        if (mAccA) begin
            expQ.push_back('{data: bus.a_data, src: 1'b0, cyc: cyc});
            mLast = 1'b0;
            mCntA = (mCntA + 1) % 256;
        end else if (mAccB) begin
            expQ.push_back('{data: bus.b_data, src: 1'b1, cyc: cyc});
            mLast = 1'b1;
            mCntB = (mCntB + 1) % 256;
        end
    endtask

    task automatic applyStimulus(input logic av, input logic [W-1:0] ad,
                                 input logic bv, input logic [W-1:0] bd,
                                 input logic ordy);
        @(negedge clk);
        bus.a_valid   = av;
        bus.a_data    = ad;
        bus.b_valid   = bv;
        bus.b_data    = bd;
        bus.out_ready = ordy;
        cyc++;
        #1;
        checkOutput();
    endtask

    // Output-side monitor: compares the presented word with the oldest expected entry.
    always @(negedge clk) begin
        #2;
        if (monEn) begin
            bit older;
            older = (expQ.size() != 0) && (expQ[0].cyc < cyc);
            compare("out_valid", 32'(bus.out_valid), 32'(older));
            if (bus.out_valid && older) begin
                compare("X", 32'(bus.X), 32'(expQ[0].data));
                compare("out_src", 32'(bus.out_src), 32'(expQ[0].src));
                if (bus.out_ready) void'(expQ.pop_front());
            end
        end
    end

    task automatic doReset();
        @(negedge clk);
        #3;
        monEn = 0;
        rst_n = 1'b0;
        bus.a_valid = 1'b1;
        bus.b_valid = 1'b1;
        #1;
        compare("rst_X", 32'(bus.X), 32'h0);
        compare("rst_out_valid", 32'(bus.out_valid), 32'h0);
        compare("rst_out_src", 32'(bus.out_src), 32'h0);
        compare("rst_a_ready", 32'(bus.a_ready), 32'h0);
        compare("rst_b_ready", 32'(bus.b_ready), 32'h0);
        modelReset();
        @(posedge clk);
        @(negedge clk);
        bus.a_valid = 1'b0;
        bus.b_valid = 1'b0;
        rst_n = 1'b1;
        monEn = 1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
    endtask

    initial begin
        logic         av, bv, ordy;
        logic [W-1:0] ad, bd;
        rst_n         = 1'b0;
        bus.a_valid   = 1'b0;
        bus.a_data    = '0;
        bus.b_valid   = 1'b0;
        bus.b_data    = '0;
        bus.out_ready = 1'b0;
        modelReset();
        repeat (2) @(posedge clk);
        doReset();

        // A wins the first tie after reset
        applyStimulus(1'b1, 4'hA, 1'b1, 4'h2, 1'b1);
        applyStimulus(1'b0, 4'h0, 1'b1, 4'h2, 1'b1);
        idle(2);

        // Alternation with both held valid
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 4'h3, 1'b1, 4'hC, 1'b1);
        idle(2);

        // Single requester B
        for (int i = 1; i <= 4; i++) applyStimulus(1'b0, 4'h0, 1'b1, 4'(i), 1'b1);
        idle(2);

        // Backpressure then release with A waiting
        applyStimulus(1'b1, 4'h5, 1'b0, 4'h0, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 4'h6, 1'b0, 4'h0, 1'b0);
        applyStimulus(1'b1, 4'h6, 1'b0, 4'h0, 1'b1);
        idle(3);

        // Drain/idle: sel keeps last value
        applyStimulus(1'b0, 4'h0, 1'b1, 4'h9, 1'b1);
        idle(3);

        // Reset mid-transfer with a held word
        applyStimulus(1'b1, 4'h7, 1'b0, 4'h0, 1'b0);
        applyStimulus(1'b0, 4'h0, 1'b0, 4'h0, 1'b0);
        compare("held_out_valid", 32'(bus.out_valid), 32'h1);
        doReset();
        applyStimulus(1'b1, 4'hA, 1'b1, 4'h2, 1'b1);
        idle(2);

        // Random traffic; a requester keeps valid/data until accepted
        av = 1'b0; bv = 1'b0; ad = '0; bd = '0;
        for (int i = 0; i < 600; i++) begin
            if (!(av && !mAccA)) begin
                av = 1'($urandom_range(0, 1));
                ad = W'($urandom);
            end
            if (!(bv && !mAccB)) begin
                bv = 1'($urandom_range(0, 1));
                bd = W'($urandom);
            end
            ordy = ($urandom_range(0, 3) != 0);
            applyStimulus(av, ad, bv, bd, ordy);
        end
        idle(3);
        compare("queue_drained", 32'(expQ.size()), 32'h0);

`ifdef MUX2_RR_ARBITER_STATS_EN
        compare("cnt_a_random", 32'(bus.cnt_a), 32'(mCntA));
        compare("cnt_b_random", 32'(bus.cnt_b), 32'(mCntB));
        doReset();
        for (int i = 0; i < 257; i++) applyStimulus(1'b1, W'(i), 1'b0, 4'h0, 1'b1);
        idle(2);
        compare("cnt_a_wrap", 32'(bus.cnt_a), 32'h1);
        compare("cnt_b_wrap", 32'(bus.cnt_b), 32'h0);
        compare("cnt_a_model", 32'(bus.cnt_a), 32'(mCntA));
`endif

        monEn = 0;
        $display("[TB] Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
